// File: rtl/cnn_conv_acc_quant.sv
// Convolution accumulator: sums N_TAPS signed products plus bias, then requantizes to 14-bit signed.
// Optional macro CNN_ACC_RELU_EN clamps negative results to zero before saturation.
module cnn_conv_acc_quant #(
  parameter int N_TAPS    = 150,
  parameter int ACC_WIDTH = 32,
  parameter int SHIFT     = 9
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        prod_valid,
  output logic        prod_ready,
  input  logic [22:0] prod_data,
  input  logic [22:0] bias,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [13:0] out_data,
  output logic        sat
);
  localparam int CW = $clog2(N_TAPS);
  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;
  localparam logic [CW-1:0] LAST_TAP = CW'(N_TAPS - 1);
  localparam logic signed [ACC_WIDTH-1:0] MAXV = ACC_WIDTH'(8191);
  localparam logic signed [ACC_WIDTH-1:0] MINV = -ACC_WIDTH'(8192);

  logic [0:0]                  r_state;
  logic [CW-1:0]               r_tap;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic [13:0]                 r_data;
  logic                        r_sat;

  logic                        w_xfer, w_last, w_pop, w_clip;
  logic signed [ACC_WIDTH-1:0] w_base, w_sum, w_shift, w_clip_in;
  logic [13:0]                 w_q;

  assign out_valid  = (r_state == ST_HOLD);
  assign out_data   = r_data;
  assign sat        = r_sat;
  assign prod_ready = !out_valid || out_ready;

  assign w_xfer = prod_valid && prod_ready;
  assign w_last = (r_tap == LAST_TAP);
  assign w_pop  = out_valid && out_ready;

  // Tap 0 seeds the window with bias instead of the stale previous sum.
  assign w_base  = (r_tap == '0) ? ACC_WIDTH'($signed(bias)) : r_acc;
  assign w_sum   = w_base + ACC_WIDTH'($signed(prod_data));
  assign w_shift = w_sum >>> SHIFT;

`ifdef CNN_ACC_RELU_EN
  assign w_clip_in = w_shift[ACC_WIDTH-1] ? '0 : w_shift;
`else
  assign w_clip_in = w_shift;
`endif

  always_comb begin
    w_clip = 1'b0;
    w_q    = w_clip_in[13:0];
    if (w_clip_in > MAXV) begin
      w_clip = 1'b1;
      w_q    = 14'h1FFF;
    end else if (w_clip_in < MINV) begin
      w_clip = 1'b1;
      w_q    = 14'h2000;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= ST_ACCUM;
      r_tap   <= '0;
      r_acc   <= '0;
      r_data  <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_sat <= 1'b0;
      if (w_xfer) begin
        r_tap <= w_last ? '0 : r_tap + CW'(1);
        r_acc <= w_sum;
      end
      // A completing pixel wins over a pop on the same edge: valid stays high with new data.
      if (w_xfer && w_last) begin
        r_state <= ST_HOLD;
        r_data  <= w_q;
        r_sat   <= w_clip;
      end else if (w_pop) begin
        r_state <= ST_ACCUM;
      end
    end
  end
endmodule

// File: tb/tb_cnn_conv_acc_quant.sv
// Directed bench for cnn_conv_acc_quant with N_TAPS=4, SHIFT=2; expectations hand-computed.
module tb_cnn_conv_acc_quant;
  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        prod_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [22:0] prod_data = '0;
  logic [22:0] bias = '0;
  logic        prod_ready, out_valid, sat;
  logic [13:0] out_data;
  int checks = 0;
  int errors = 0;

  always #5 ap_clk = ~ap_clk;

  cnn_conv_acc_quant #(.N_TAPS(4), .ACC_WIDTH(32), .SHIFT(2)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .prod_valid(prod_valid), .prod_ready(prod_ready),
    .prod_data(prod_data), .bias(bias),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .sat(sat)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat transferred.
  task automatic beat(input int p, input int b);
    int n;
    prod_valid = 1'b1;
    prod_data  = 23'(p);
    bias       = 23'(b);
    n = 0;
    #1;
    while (!prod_ready && n < 20) begin
      @(negedge ap_clk);
      #1;
      n++;
    end
    chk("beat_ready", {31'd0, prod_ready}, 32'd1);
    @(posedge ap_clk);
    @(negedge ap_clk);
    prod_valid = 1'b0;
    prod_data  = '0;
  endtask

  // Non-first taps carry a junk bias that must be ignored.
  task automatic window(input string tag, input int p0, input int p1, input int p2, input int p3, input int b);
    beat(p0, b);
    beat(p1, 12345);
    @(negedge ap_clk);
    beat(p2, -777);
    chk({tag, "_vld_before"}, {31'd0, out_valid}, 32'd0);
    beat(p3, 999);
    chk({tag, "_vld_after"}, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic pop(input string tag);
    @(posedge ap_clk);
    @(negedge ap_clk);
    chk({tag, "_pop_vld"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_pop_sat"}, {31'd0, sat}, 32'd0);
  endtask

  initial begin
    #1;
    chk("rst_vld", {31'd0, out_valid}, 32'd0);
    chk("rst_rdy", {31'd0, prod_ready}, 32'd1);
    chk("rst_data", {18'd0, out_data}, 32'd0);
    chk("rst_sat", {31'd0, sat}, 32'd0);
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);

    window("pos", 100, 200, 300, 400, 0);
    chk("pos_data", {18'd0, out_data}, 32'd250);
    chk("pos_sat", {31'd0, sat}, 32'd0);
    pop("pos");

    window("neg", -100, -100, -100, -100, 0);
`ifdef CNN_ACC_RELU_EN
    chk("neg_data", {18'd0, out_data}, 32'd0);
`else
    chk("neg_data", {18'd0, out_data}, 32'h3F9C);
`endif
    chk("neg_sat", {31'd0, sat}, 32'd0);
    pop("neg");

    window("satp", 4000000, 4000000, 4000000, 4000000, 0);
    chk("satp_data", {18'd0, out_data}, 32'h1FFF);
    chk("satp_sat", {31'd0, sat}, 32'd1);
    pop("satp");

    window("satn", -4000000, -4000000, -4000000, -4000000, 0);
`ifdef CNN_ACC_RELU_EN
    chk("satn_data", {18'd0, out_data}, 32'd0);
    chk("satn_sat", {31'd0, sat}, 32'd0);
`else
    chk("satn_data", {18'd0, out_data}, 32'h2000);
    chk("satn_sat", {31'd0, sat}, 32'd1);
`endif
    pop("satn");

    // Bias 8 with taps 1..4: (8+10)>>2 = 4
    window("bias", 1, 2, 3, 4, 8);
    chk("bias_data", {18'd0, out_data}, 32'd4);
    pop("bias");

    // Backpressure: pixel 16>>2=4 held while the next window's first beat waits
    window("bp", 4, 4, 4, 4, 0);
    out_ready  = 1'b0;
    prod_valid = 1'b1;
    prod_data  = 23'd40;
    bias       = 23'd0;
    for (int i = 0; i < 3; i++) begin
      @(posedge ap_clk);
      @(negedge ap_clk);
      #1;
      chk("bp_hold_vld", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_data", {18'd0, out_data}, 32'd4);
      chk("bp_hold_rdy", {31'd0, prod_ready}, 32'd0);
      chk("bp_hold_sat", {31'd0, sat}, 32'd0);
    end
    out_ready = 1'b1;
    beat(40, 0);
    chk("bp_popped", {31'd0, out_valid}, 32'd0);
    beat(40, 5);
    beat(40, 5);
    chk("bp2_vld_before", {31'd0, out_valid}, 32'd0);
    beat(40, 5);
    chk("bp2_vld_after", {31'd0, out_valid}, 32'd1);
    chk("bp2_data", {18'd0, out_data}, 32'd40);
    pop("bp2");

    // Mid-window reset discards the partial 10+20 sum
    beat(10, 6);
    beat(20, 0);
    ap_rst_n = 1'b0;
    #1;
    chk("mrst_vld", {31'd0, out_valid}, 32'd0);
    chk("mrst_rdy", {31'd0, prod_ready}, 32'd1);
    chk("mrst_data", {18'd0, out_data}, 32'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    window("mrst", 1, 2, 3, 4, 6);
    chk("mrst_result", {18'd0, out_data}, 32'd4);
    pop("mrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cnn_conv_acc_quant.md
CNN_CONV_ACC_QUANT -- requirements
Module: cnn_conv_acc_quant

Interface
REQ-001 SHALL provide parameter N_TAPS, default 150, products per output pixel (5x5 kernel x 6 input channels); legal range 2..1023.
REQ-002 SHALL provide parameter ACC_WIDTH, default 32, signed accumulator width.
REQ-003 SHALL provide parameter SHIFT, default 9, arithmetic right-shift applied at requantization; legal range 0..ACC_WIDTH-14.
REQ-004 SHALL provide ports: ap_clk  in  1  sole clock, rising edge.
REQ-005 ap_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 prod_valid  in  1  product beat valid.
REQ-007 prod_ready  out  1  block accepts product beat.
REQ-008 prod_data  in  23  signed 14s x 9s multiplier product.
REQ-009 bias  in  23  signed bias, sampled only on the first tap of a window.
REQ-010 out_valid  out  1  output pixel valid.
REQ-011 out_ready  in  1  downstream accepts pixel.
REQ-012 out_data  out  14  signed requantized pixel.
REQ-013 sat  out  1  one-cycle pulse: the pixel just produced was clipped.

Function
REQ-014 A beat SHALL transfer when prod_valid and prod_ready are both high on a rising edge.
REQ-015 prod_ready SHALL equal (not out_valid) or out_ready, combinationally.
REQ-016 A tap counter SHALL run 0..N_TAPS-1, increment per transferred beat, and wrap to 0 after N_TAPS-1.
REQ-017 On tap 0, acc SHALL load sign_extend(bias) + sign_extend(prod_data); on other taps, acc SHALL load acc + sign_extend(prod_data).
REQ-018 Accumulator arithmetic SHALL be two's complement at ACC_WIDTH bits; wrap beyond ACC_WIDTH is the caller's responsibility (default sizing never wraps).
REQ-019 On the transfer of tap N_TAPS-1, the final sum SHALL be computed, shifted right arithmetically by SHIFT, and saturated to [-8192, 8191]; out_data and out_valid SHALL be registered on that same edge, so out_valid is high the cycle after the last tap is accepted.
REQ-020 sat SHALL be high for exactly the cycle out_valid first rises for a pixel whose shifted value was outside [-8192, 8191], and low otherwise.
REQ-021 out_valid SHALL stay high and out_data SHALL stay stable until out_valid and out_ready are both high on an edge; out_valid SHALL then clear unless a new pixel completes on that same edge, in which case out_valid stays high with the new data.
REQ-022 Taps of the next window SHALL be accepted while a pixel is pending only when prod_ready is high, per REQ-015; no pixel SHALL be dropped or duplicated.
REQ-023 prod_valid low SHALL stall the counter and acc without side effects.
REQ-024 State: ACCUM (taps counting) and HOLD (out_valid high, out_ready low). HOLD SHALL be left only through an out_ready handshake.

Reset
REQ-025 While ap_rst_n is low, the block SHALL clear tap counter, acc, out_data, out_valid and sat to 0 immediately; prod_ready then reads 1.
REQ-026 Reset mid-window SHALL discard the partial sum; the first beat after release SHALL be tap 0.

Configuration
REQ-027 Macro CNN_ACC_RELU_EN: when defined, negative shifted values SHALL be forced to 0 before saturation, and sat SHALL flag only positive clipping; when undefined, signed values pass to saturation unchanged.

Verification
All scenarios use N_TAPS=4 and SHIFT=2.
REQ-028 Taps 100, 200, 300, 400 with bias 0 -> out_data 250, out_valid exactly one cycle after the 4th beat, sat 0.
REQ-029 Taps -100 x4 with bias 0 -> out_data -100 (0x3F9C) without CNN_ACC_RELU_EN; out_data 0 with it.
REQ-030 Taps 4000000 x4 -> out_data 8191 and sat pulses one cycle; taps -4000000 x4 without ReLU -> out_data -8192 and sat pulses.
REQ-031 out_ready low for 3 cycles after a pixel -> out_data stable, prod_ready 0 for those cycles, and the second window's beats are held off; on out_ready high the next pixel follows with no loss.
REQ-032 Taps 10, 20, ap_rst_n pulsed low, then taps 1, 2, 3, 4 with bias 6 -> out_data 4 ((6+10)>>2).
